wb_cycle_monitor: RTL and testbench
===================================

Name: wb_cycle_monitor

Overview:
- Passive performance and progress monitor attached to the writeback (WB) stage of the pipelined RISC-V core.
- Counts clock cycles, retired instructions, WB stalls and WB bubbles, and keeps a per-class histogram of retired instructions decoded from the opcode.
- Raises a timeout flag once the cycle count exceeds a limit; the system bench uses it to end runaway simulations.
- Has no effect on the core; all inputs are observe-only.

Parameters:
- CNT_W, 64, width of every counter.
- MAX_CYCLES, 1000000, timeout threshold (compared strictly greater-than).

Ports:
- clk_i  in  1  clock, rising-edge.
- reset_i  in  1  asynchronous, active-high reset.
- valid_wb_i  in  1  WB stage holds a valid instruction.
- stall_wb_i  in  1  WB stage is stalled this cycle.
- instr_wb_i  in  32  instruction word in WB.
- cycle_cnt_o  out  CNT_W  cycles since reset release.
- instret_cnt_o  out  CNT_W  retired instructions.
- stall_cnt_o  out  CNT_W  stalled cycles.
- bubble_cnt_o  out  CNT_W  empty (bubble) cycles.
- load_cnt_o, store_cnt_o, branch_cnt_o, jump_cnt_o, alu_cnt_o, system_cnt_o, other_cnt_o  out  CNT_W each  retired instructions per class.
- last_instr_o  out  32  most recently retired instruction word.
- timeout_o  out  1  cycle_cnt_o > MAX_CYCLES.

Behaviour:
- Reset: all counters 0, last_instr_o = 32'h0000_0013 (NOP), timeout_o = 0. Reset is asynchronous; asserting it mid-run clears everything immediately.
- Counter update: every rising edge while reset_i is low, cycle_cnt increments by 1. The first edge after release gives 1.
- Per-cycle classification, exactly one event per cycle:
  - retire = valid_wb_i && !stall_wb_i
  - stall = stall_wb_i (regardless of valid)
  - bubble = !valid_wb_i && !stall_wb_i
- Counter increments: retire increments instret; stall increments stall_cnt; bubble increments bubble_cnt.
- Invariants (modulo 2^CNT_W):
  - instret + stall + bubble == cycle
  - sum of the seven class counters == instret
- On retire, last_instr_o <= instr_wb_i and exactly one class counter increments, chosen by instr_wb_i[6:0]:
  - load: 0000011
  - store: 0100011
  - branch: 1100011
  - jump: 1101111 (JAL) or 1100111 (JALR)
  - alu: 0110011, 0010011, 0110111 (LUI), 0010111 (AUIPC)
  - system: 1110011 (CSR/ECALL/EBREAK)
  - other: anything else, including FENCE and illegal opcodes
- Class decode uses only the opcode field. instr_wb_i is ignored when not retiring.
- All counter outputs are registered. Values reflect events up to and including the last clock edge (1-cycle latency from input to count).
- timeout_o = (cycle_cnt_o > MAX_CYCLES), combinational compare of the register. It is sticky in practice because the counter only increases.
- Overflow: counters wrap modulo 2^CNT_W with no saturation and no flag.
- X on valid_wb_i or stall_wb_i is treated as 0. The monitor must not propagate X into counters before the core leaves reset.

Decomposition:
- Shared package wb_mon_pkg:
  - opcode localparams (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_SYSTEM)
  - enum instr_class_t {CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ALU, CLS_SYSTEM, CLS_OTHER}
  - NOP constant 32'h0000_0013
- One combinational sub-module instr_class_decode: takes opcode[6:0], returns instr_class_t.
- Counters live in the top. A class-indexed counter array is acceptable.

Test Plan:
- Reset then 10 cycles with valid=0, stall=0 -> cycle=10, bubble=10, instret=0, stall=0, last_instr=0x00000013.
- Retire 0x00000003 (lw), 0x00002023 (sw), 0x00000063 (beq), 0x0000006F (jal), 0x00000067 (jalr), 0x00000033 (add), 0x00000073 (ecall), 0x0000000F (fence), one per cycle -> load=1, store=1, branch=1, jump=2, alu=1, system=1, other=1, instret=8, last_instr=0x0000000F.
- 5 cycles valid=1, stall=1, instr=0x00000033, then 5 cycles valid=0, stall=1 -> stall=10, instret=0, alu=0; invariant instret+stall+bubble==cycle holds.
- Override MAX_CYCLES=20, run 25 cycles -> timeout_o low through cycle_cnt=20, high from cycle_cnt=21 onward.
- After 50 mixed cycles, assert reset_i asynchronously between edges -> all outputs 0 (last_instr=NOP, timeout=0) immediately. After release, the first edge gives cycle=1.
- CNT_W=4, run 17 cycles -> cycle_cnt wraps to 1. No X on any output at any time.

Source files
------------

// File: rtl/wb_mon_pkg.sv
// Shared definitions for the writeback-stage monitor: RISC-V opcodes,
// instruction classes and the reset value of the last-retired register.
package wb_mon_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_ALU,
      CLS_SYSTEM,
      CLS_OTHER
   } instr_class_t;

   localparam int NUM_CLASSES = 7;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/wb_cycle_monitor_if.sv
// Writeback-stage observation bus: the core drives it, the monitor only listens.
interface wb_cycle_monitor_if;
   logic        valid_wb;
   logic        stall_wb;
   logic [31:0] instr_wb;

   modport master (output valid_wb, stall_wb, instr_wb);
   modport slave  (input  valid_wb, stall_wb, instr_wb);
endinterface

// File: rtl/wb_cycle_monitor_decode.sv
// Maps a RISC-V major opcode onto one of the monitor's instruction classes.
module instr_class_decode
   import wb_mon_pkg::*;
(
   input  logic [6:0]   opcode,
   output instr_class_t cls
);

   always_comb begin
      cls = CLS_OTHER;
      case (opcode)
         OPC_LOAD:                               cls = CLS_LOAD;
         OPC_STORE:                              cls = CLS_STORE;
         OPC_BRANCH:                             cls = CLS_BRANCH;
         OPC_JAL, OPC_JALR:                      cls = CLS_JUMP;
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: cls = CLS_ALU;
         OPC_SYSTEM:                             cls = CLS_SYSTEM;
         default:                                cls = CLS_OTHER;
      endcase
   end

endmodule

// File: rtl/wb_cycle_monitor.sv
// Passive WB-stage monitor: cycle/retire/stall/bubble counters, per-class
// retire histogram, last retired instruction and a cycle-limit timeout flag.
module wb_cycle_monitor
   import wb_mon_pkg::*;
#(
   parameter int              CNT_W      = 64,
   parameter longint unsigned MAX_CYCLES = 1000000
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   wb_cycle_monitor_if.slave    wb,
   output logic [CNT_W-1:0]     cycle_cnt_o,
   output logic [CNT_W-1:0]     instret_cnt_o,
   output logic [CNT_W-1:0]     stall_cnt_o,
   output logic [CNT_W-1:0]     bubble_cnt_o,
   output logic [CNT_W-1:0]     load_cnt_o,
   output logic [CNT_W-1:0]     store_cnt_o,
   output logic [CNT_W-1:0]     branch_cnt_o,
   output logic [CNT_W-1:0]     jump_cnt_o,
   output logic [CNT_W-1:0]     alu_cnt_o,
   output logic [CNT_W-1:0]     system_cnt_o,
   output logic [CNT_W-1:0]     other_cnt_o,
   output logic [31:0]          last_instr_o,
   output logic                 timeout_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             retire;
   logic             stall;
   logic             bubble;
   instr_class_t     cls;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;
   logic [CNT_W-1:0] cls_cnt [NUM_CLASSES];
   logic [31:0]      last_instr;

   // The three events are mutually exclusive and cover every cycle.
   assign retire = wb.valid_wb && !wb.stall_wb;
   assign stall  = wb.stall_wb;
   assign bubble = !wb.valid_wb && !wb.stall_wb;

   instr_class_decode u_decode (
      .opcode (wb.instr_wb[6:0]),
      .cls    (cls)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
         stall_cnt   <= '0;
         bubble_cnt  <= '0;
         last_instr  <= NOP_INSTR;
         for (int i = 0; i < NUM_CLASSES; i++) begin
            cls_cnt[i] <= '0;
         end
      end else begin
         cycle_cnt <= cycle_cnt + CNT_ONE;
         if (retire) begin
            instret_cnt <= instret_cnt + CNT_ONE;
            last_instr  <= wb.instr_wb;
         end
         if (stall) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (bubble) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
         end
         for (int i = 0; i < NUM_CLASSES; i++) begin
            if (retire && (int'(cls) == i)) begin
               cls_cnt[i] <= cls_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   assign cycle_cnt_o   = cycle_cnt;
   assign instret_cnt_o = instret_cnt;
   assign stall_cnt_o   = stall_cnt;
   assign bubble_cnt_o  = bubble_cnt;
   assign load_cnt_o    = cls_cnt[CLS_LOAD];
   assign store_cnt_o   = cls_cnt[CLS_STORE];
   assign branch_cnt_o  = cls_cnt[CLS_BRANCH];
   assign jump_cnt_o    = cls_cnt[CLS_JUMP];
   assign alu_cnt_o     = cls_cnt[CLS_ALU];
   assign system_cnt_o  = cls_cnt[CLS_SYSTEM];
   assign other_cnt_o   = cls_cnt[CLS_OTHER];
   assign last_instr_o  = last_instr;

   // Compared at 64 bits so a narrow counter never truncates the limit.
   assign timeout_o = 64'(cycle_cnt) > MAX_CYCLES;

endmodule

// File: tb/tb_wb_cycle_monitor.sv
// Self-checking bench: a wide monitor (limit 20) and a 4-bit monitor (limit 10)
// watch the same WB bus and are compared every cycle against a count model.
module tb_wb_cycle_monitor;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wb_cycle_monitor_if wb_bus ();

   logic [63:0] a_cyc, a_ret, a_stl, a_bub, a_ld, a_st, a_br, a_jmp, a_alu, a_sys, a_oth;
   logic [31:0] a_last;
   logic        a_to;
   logic [3:0]  b_cyc, b_ret, b_stl, b_bub, b_ld, b_st, b_br, b_jmp, b_alu, b_sys, b_oth;
   logic [31:0] b_last;
   logic        b_to;

   wb_cycle_monitor #(.CNT_W(64), .MAX_CYCLES(20)) dut_a (
      .clk_i(clk), .reset_i(rst), .wb(wb_bus),
      .cycle_cnt_o(a_cyc), .instret_cnt_o(a_ret), .stall_cnt_o(a_stl), .bubble_cnt_o(a_bub),
      .load_cnt_o(a_ld), .store_cnt_o(a_st), .branch_cnt_o(a_br), .jump_cnt_o(a_jmp),
      .alu_cnt_o(a_alu), .system_cnt_o(a_sys), .other_cnt_o(a_oth),
      .last_instr_o(a_last), .timeout_o(a_to)
   );

   wb_cycle_monitor #(.CNT_W(4), .MAX_CYCLES(10)) dut_b (
      .clk_i(clk), .reset_i(rst), .wb(wb_bus),
      .cycle_cnt_o(b_cyc), .instret_cnt_o(b_ret), .stall_cnt_o(b_stl), .bubble_cnt_o(b_bub),
      .load_cnt_o(b_ld), .store_cnt_o(b_st), .branch_cnt_o(b_br), .jump_cnt_o(b_jmp),
      .alu_cnt_o(b_alu), .system_cnt_o(b_sys), .other_cnt_o(b_oth),
      .last_instr_o(b_last), .timeout_o(b_to)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: plain event tallies, kept at full width and reduced per DUT.
   longint unsigned m_cyc, m_ret, m_stl, m_bub;
   longint unsigned m_cls [7];
   logic [31:0]     m_last;

   function automatic int ref_class(logic [31:0] ins);
      case (ins[6:0])
         7'h03:                      return 0;
         7'h23:                      return 1;
         7'h63:                      return 2;
         7'h6F, 7'h67:               return 3;
         7'h33, 7'h13, 7'h37, 7'h17: return 4;
         7'h73:                      return 5;
         default:                    return 6;
      endcase
   endfunction

   task automatic model_clear();
      m_cyc = 0; m_ret = 0; m_stl = 0; m_bub = 0;
      for (int i = 0; i < 7; i++) m_cls[i] = 0;
      m_last = 32'h0000_0013;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [63:0] m4;
      m4 = 64'hF;
      chk("a_cycle",   a_cyc, m_cyc);
      chk("a_instret", a_ret, m_ret);
      chk("a_stall",   a_stl, m_stl);
      chk("a_bubble",  a_bub, m_bub);
      chk("a_load",    a_ld,  m_cls[0]);
      chk("a_store",   a_st,  m_cls[1]);
      chk("a_branch",  a_br,  m_cls[2]);
      chk("a_jump",    a_jmp, m_cls[3]);
      chk("a_alu",     a_alu, m_cls[4]);
      chk("a_system",  a_sys, m_cls[5]);
      chk("a_other",   a_oth, m_cls[6]);
      chk("a_last",    64'(a_last), 64'(m_last));
      chk("a_timeout", 64'(a_to), 64'(m_cyc > 20));
      chk("b_cycle",   64'(b_cyc), m_cyc & m4);
      chk("b_instret", 64'(b_ret), m_ret & m4);
      chk("b_stall",   64'(b_stl), m_stl & m4);
      chk("b_bubble",  64'(b_bub), m_bub & m4);
      chk("b_load",    64'(b_ld),  m_cls[0] & m4);
      chk("b_store",   64'(b_st),  m_cls[1] & m4);
      chk("b_branch",  64'(b_br),  m_cls[2] & m4);
      chk("b_jump",    64'(b_jmp), m_cls[3] & m4);
      chk("b_alu",     64'(b_alu), m_cls[4] & m4);
      chk("b_system",  64'(b_sys), m_cls[5] & m4);
      chk("b_other",   64'(b_oth), m_cls[6] & m4);
      chk("b_last",    64'(b_last), 64'(m_last));
      chk("b_timeout", 64'(b_to), 64'((m_cyc & m4) > 10));
   endtask

   // Model advances on each rising edge; outputs are checked on the falling edge.
   initial begin
      model_clear();
      forever begin
         @(posedge clk);
         if (rst) begin
            model_clear();
         end else begin
            m_cyc++;
            if (wb_bus.valid_wb && !wb_bus.stall_wb) begin
               m_ret++;
               m_cls[ref_class(wb_bus.instr_wb)]++;
               m_last = wb_bus.instr_wb;
            end else if (wb_bus.stall_wb) begin
               m_stl++;
            end else begin
               m_bub++;
            end
         end
         @(negedge clk);
         if (rst) model_clear();
         compare_all();
      end
   end

   task automatic cyc(input logic v, input logic s, input logic [31:0] ins);
      wb_bus.valid_wb = v;
      wb_bus.stall_wb = s;
      wb_bus.instr_wb = ins;
      @(posedge clk);
      #2;
   endtask

   logic [31:0] retire_seq [8] = '{32'h0000_0003, 32'h0000_2023, 32'h0000_0063, 32'h0000_006F,
                                   32'h0000_0067, 32'h0000_0033, 32'h0000_0073, 32'h0000_000F};

   initial begin
      wb_bus.valid_wb = 1'b0;
      wb_bus.stall_wb = 1'b0;
      wb_bus.instr_wb = 32'h0;
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_cycle",   a_cyc, 64'd0);
      chk("rst_last",    64'(a_last), 64'h13);
      chk("rst_timeout", 64'(a_to), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'hDEAD_BEEF);
      chk("idle_cycle",   a_cyc, 64'd10);
      chk("idle_bubble",  a_bub, 64'd10);
      chk("idle_instret", a_ret, 64'd0);
      chk("idle_stall",   a_stl, 64'd0);
      chk("idle_last",    64'(a_last), 64'h13);

      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, retire_seq[i]);
      chk("cls_load",    a_ld,  64'd1);
      chk("cls_store",   a_st,  64'd1);
      chk("cls_branch",  a_br,  64'd1);
      chk("cls_jump",    a_jmp, 64'd2);
      chk("cls_alu",     a_alu, 64'd1);
      chk("cls_system",  a_sys, 64'd1);
      chk("cls_other",   a_oth, 64'd1);
      chk("cls_instret", a_ret, 64'd8);
      chk("cls_last",    64'(a_last), 64'h0F);
      chk("b_wrap_18",   64'(b_cyc), 64'd2);

      for (int i = 0; i < 10; i++) begin
         if (i < 5) cyc(1'b1, 1'b1, 32'h0000_0033);
         else       cyc(1'b0, 1'b1, 32'h0000_0033);
         if (i == 1) chk("to_at_20", 64'(a_to), 64'd0);
         if (i == 2) chk("to_at_21", 64'(a_to), 64'd1);
      end
      chk("stl_stall",   a_stl, 64'd10);
      chk("stl_instret", a_ret, 64'd8);
      chk("stl_alu",     a_alu, 64'd1);
      chk("stl_cycle",   a_cyc, 64'd28);

      for (int i = 0; i < 22; i++) begin
         logic [31:0] ins;
         ins = retire_seq[$urandom_range(7, 0)] | {$urandom_range(255, 0), 7'h0};
         cyc(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), ins);
      end
      chk("mix_cycle", a_cyc, 64'd50);

      #1 rst = 1'b1;
      #1;
      chk("arst_cycle",   a_cyc, 64'd0);
      chk("arst_instret", a_ret, 64'd0);
      chk("arst_stall",   a_stl, 64'd0);
      chk("arst_last",    64'(a_last), 64'h13);
      chk("arst_timeout", 64'(a_to), 64'd0);
      chk("arst_b_cycle", 64'(b_cyc), 64'd0);
      @(negedge clk);
      #1 rst = 1'b0;

      cyc(1'b0, 1'b0, 32'h0);
      chk("rel_cycle", a_cyc, 64'd1);
      for (int i = 1; i < 17; i++) cyc(1'b0, 1'b0, 32'h0);
      chk("wrap_b_cycle",  64'(b_cyc), 64'd1);
      chk("wrap_b_bubble", 64'(b_bub), 64'd1);
      chk("wrap_a_cycle",  a_cyc, 64'd17);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
